sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Two-port arbiter and sequencer for the command/read interface of `SDRAM_Controller_v`. It lets two independent requesters share the single 100 MHz SDRAM command port: port 0 is the sampler write path and port 1 is the UART read-back/dump path. It arbitrates round-robin, issues one command at a time, and routes read data back to the issuing port. A timeout recovers the port if the controller never responds.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles allowed in ISSUE plus WAIT_RD before abort; must be ≥ 2.

Ports:
- `clk` in 1: system clock (`clk100`).
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: request. Hold high with fields stable until the matching `ack` is seen.
- `wr0`, `wr1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in 23: word address.
- `wdata0`, `wdata1` in 32: write data.
- `be0`, `be1` in 4: byte enables.
- `ack0`, `ack1` out 1: one-cycle pulse when the request is latched.
- `done0`, `done1` out 1: one-cycle pulse when the command completes or is aborted.
- `rdata` out 32: read data. Valid in the cycle `doneN` is high for a read.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: sticky; set on any abort.
- `cmd_ready` in 1: from the controller.
- `cmd_enable` out 1: to the controller.
- `cmd_wr` out 1: to the controller.
- `cmd_address` out 23: to the controller.
- `cmd_data_in` out 32: to the controller.
- `cmd_byte_enable` out 4: to the controller.
- `data_out` in 32: read data from the controller.
- `data_out_ready` in 1: read-data strobe from the controller.

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any `reqN` is high, grant one port.
  - Latch its `wr`, `addr`, `wdata` and `be` into the `cmd_*` registers.
  - Set the owner register and `last_grant`, pulse `ackN`, clear the timeout counter, go to ISSUE.
- Round-robin:
  - Single requester: it wins.
  - Both requesting: the port ≠ `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- ISSUE:
  - `cmd_enable` = (state == ISSUE). This is the only combinational output.
  - The command is accepted on the first edge where `cmd_ready` = 1.
  - Write accepted: pulse `done[owner]` and go to IDLE. Writes are posted.
  - Read accepted: go to WAIT_RD.
- WAIT_RD:
  - On the edge where `data_out_ready` = 1: `rdata` ← `data_out`, pulse `done[owner]`, go to IDLE.
- Timeout:
  - The counter increments every cycle in ISSUE or WAIT_RD.
  - When it reaches `TIMEOUT`−1 without completion: pulse `done[owner]`, leave `rdata` unchanged, set `timeout_err`, go to IDLE.
  - Counter width is clog2(`TIMEOUT`)+1.
- Ignored inputs:
  - `data_out_ready` in IDLE or ISSUE is ignored (stale strobe after an abort).
  - Requests arriving while not in IDLE are not sampled; they wait.
- Reset values:
  - State IDLE.
  - All `ack`, `done`, `busy`, `timeout_err` = 0.
  - `rdata`, `cmd_address`, `cmd_data_in`, `cmd_byte_enable`, `cmd_wr` = 0.
  - `cmd_enable` = 0, `last_grant` = 1.
- Reset mid-operation aborts the current command silently: no `done`, and `timeout_err` is cleared.
- `timeout_err` is cleared only by `rst`.

## Timing
- Grant: `req` sampled high at IDLE edge k → `ackN` high and `cmd_enable` high in cycle k+1.
- Write with `cmd_ready` already high:
  - Accepted at edge k+1.
  - `doneN` high in cycle k+2.
  - Next grant possible at edge k+2.
- Read:
  - `doneN` and `rdata` valid the cycle after the `data_out_ready` edge.
  - Minimum latency from `req` to `done` is 3 edges.
- Requester rule: drop `req` at the edge where `ack` is seen (k+1). `req` still high at edge k+2 is treated as a new request.
- `ack` and `done` are never high on both ports in the same cycle.
- `done` is never asserted in the same cycle as `ack` of the same transaction.
- Back-to-back alternating requests sustain one write per 2 cycles when `cmd_ready` stays high.

## Structure
- Package `sdram_arb_pkg`:
  - State encoding.
  - `ADDR_W` = 23, `DATA_W` = 32, `BE_W` = 4.
  - Port index constants `PORT_SAMPLER` = 0, `PORT_UART` = 1.
- Sub-module `sdram_rr_pick`: two-request round-robin selector (inputs `req[1:0]`, `last_grant`; outputs `grant_valid`, `grant_idx`).
- Everything else lives in the top module.

## Test plan
- Single write: port 0 writes `addr` 0x000010, `wdata` 0xA5A5_0001 with `cmd_ready` = 1. Expect:
  - `ack0` in cycle +1, `cmd_enable` for exactly 1 cycle with matching fields.
  - `done0` in cycle +2, `busy` low in cycle +2.
- Read routing: port 1 reads 0x000010 and the model returns 0xA5A5_0001 five cycles after accept. Expect:
  - `done1` with `rdata` = 0xA5A5_0001.
  - `done0` never pulses.
- Tie and fairness: both ports hold writes continuously for 6 grants. Expect:
  - Grant order 0,1,0,1,0,1.
  - No `ack` on both ports in the same cycle.
- Backpressure: `cmd_ready` is held low for 20 cycles during ISSUE. Expect:
  - `cmd_enable` stays high and the fields stay stable.
  - Accept on the first `cmd_ready` edge.
- Timeout: `TIMEOUT` = 16 and a read with no `data_out_ready`. Expect:
  - `done` 16 cycles after entering ISSUE.
  - `timeout_err` = 1 and `rdata` unchanged.
  - A late `data_out_ready` in IDLE is ignored.
- Reset mid-read: assert `rst` in WAIT_RD. Expect:
  - All outputs at reset values immediately (asynchronous).
  - No `done`.
  - Port 0 wins the first tie after release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared widths, port indices and state encoding for the two-port SDRAM
// command arbiter.
package sdram_arb_pkg;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic PORT_SAMPLER = 1'b0;
  localparam logic PORT_UART    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_e;
endpackage

// File: rtl/sdram_rr_pick.sv
// Two-request round-robin selector: on a tie the port that did not win last
// time is chosen.
module sdram_rr_pick
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);
  assign grant_valid = |req;
  assign grant_idx   = (&req) ? ~last_grant : (req[1] ? PORT_UART : PORT_SAMPLER);
endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command port between the sampler (port 0) and
// the UART dump path (port 1); one command in flight, read data routed back.
//   state      | meaning
//   ST_IDLE    | waiting for a request, grants one port
//   ST_ISSUE   | cmd_enable high until the controller takes the command
//   ST_WAIT_RD | read accepted, waiting for data_out_ready
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [BE_W-1:0]   be0,
  input  logic [BE_W-1:0]   be1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              timeout_err,
  input  logic              cmd_ready,
  output logic              cmd_enable,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_address,
  output logic [DATA_W-1:0] cmd_data_in,
  output logic [BE_W-1:0]   cmd_byte_enable,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_ready
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        done_q, done_d;
  logic              busy_q, busy_d;
  logic              terr_q, terr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              grant_valid, grant_idx;
  logic              expired;

  sdram_rr_pick u_pick (
    .req         ({req1, req0}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // >= rather than == so a read accepted on the last ISSUE cycle still aborts.
  assign expired = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= PORT_SAMPLER;
      last_grant_q <= PORT_UART;
      ack_q        <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      rdata_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
      rdata_q      <= rdata_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_valid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (cmd_ready)    state_d = wr_q ? ST_IDLE : ST_WAIT_RD;
        else if (expired) state_d = ST_IDLE;
      end
      ST_WAIT_RD: if (data_out_ready || expired) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    done_d       = '0;
    terr_d       = terr_q;
    rdata_d      = rdata_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    busy_d       = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d          = grant_idx;
          last_grant_d     = grant_idx;
          ack_d[grant_idx] = 1'b1;
          cnt_d            = '0;
          wr_d             = (grant_idx == PORT_UART) ? wr1    : wr0;
          addr_d           = (grant_idx == PORT_UART) ? addr1  : addr0;
          wdata_d          = (grant_idx == PORT_UART) ? wdata1 : wdata0;
          be_d             = (grant_idx == PORT_UART) ? be1    : be0;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cmd_ready) begin
          if (wr_q) done_d[owner_q] = 1'b1;
        end else if (expired) begin
          done_d[owner_q] = 1'b1;
          terr_d          = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (data_out_ready) begin
          rdata_d         = data_out;
          done_d[owner_q] = 1'b1;
        end else if (expired) begin
          done_d[owner_q] = 1'b1;
          terr_d          = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cmd_enable      = (state_q == ST_ISSUE);
  assign ack0            = ack_q[0];
  assign ack1            = ack_q[1];
  assign done0           = done_q[0];
  assign done1           = done_q[1];
  assign busy            = busy_q;
  assign timeout_err     = terr_q;
  assign rdata           = rdata_q;
  assign cmd_wr          = wr_q;
  assign cmd_address     = addr_q;
  assign cmd_data_in     = wdata_q;
  assign cmd_byte_enable = be_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: table of single-port transactions, directed
// tie/timeout/reset sequences, and a randomized run against a reference model.
module tb_sdram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [22:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic [3:0]  be0 = 0, be1 = 0;
  logic        cmd_ready = 0, data_out_ready = 0;
  logic [31:0] data_out = 0;

  logic        ack0, ack1, done0, done1, busy, timeout_err, cmd_enable, cmd_wr;
  logic [31:0] rdata, cmd_data_in;
  logic [22:0] cmd_address;
  logic [3:0]  cmd_byte_enable;

  logic        ack0_t, ack1_t, done0_t, done1_t, busy_t, terr_t, en_t, cwr_t;
  logic [31:0] rdata_t, cdata_t;
  logic [22:0] caddr_t;
  logic [3:0]  cbe_t;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] smem [logic [22:0]];
  logic [31:0] gmem [logic [22:0]];

  typedef struct {
    bit          port;
    bit          wr;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdy;
    int          dly;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .timeout_err(timeout_err),
    .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
    .cmd_byte_enable(cmd_byte_enable),
    .data_out(data_out), .data_out_ready(data_out_ready)
  );

  sdram_port_arbiter #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1),
    .ack0(ack0_t), .ack1(ack1_t), .done0(done0_t), .done1(done1_t),
    .rdata(rdata_t), .busy(busy_t), .timeout_err(terr_t),
    .cmd_ready(cmd_ready), .cmd_enable(en_t), .cmd_wr(cwr_t),
    .cmd_address(caddr_t), .cmd_data_in(cdata_t),
    .cmd_byte_enable(cbe_t),
    .data_out(data_out), .data_out_ready(data_out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  function automatic logic [31:0] smem_rd(input logic [22:0] a);
    return smem.exists(a) ? smem[a] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] gmem_rd(input logic [22:0] a);
    return gmem.exists(a) ? gmem[a] : 32'hDEADBEEF;
  endfunction

  task automatic set_port(input bit p, input bit r, input bit w, input logic [22:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    if (p) begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; be1 = b; end
    else   begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; be0 = b; end
  endtask

  task automatic pulse_reset();
    req0 = 0; req1 = 0; cmd_ready = 0; data_out_ready = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Bench acts as a single requester plus the controller; latency is counted in
  // edges from the grant edge (edge 1) to the sample where done is visible.
  task automatic run_vec(input vec_t v);
    int done_at, done_cnt, en_cnt, ack_cnt;
    logic ackp, acko, donep, doneo;
    done_at = 0; done_cnt = 0; en_cnt = 0; ack_cnt = 0;
    set_port(v.port, 1'b1, v.wr, v.addr, v.wdata, v.be);
    cmd_ready = (v.rdy == 0);
    data_out_ready = 0;
    for (int n = 1; n <= v.lat + 2; n++) begin
      tick();
      ackp  = v.port ? ack1 : ack0;
      acko  = v.port ? ack0 : ack1;
      donep = v.port ? done1 : done0;
      doneo = v.port ? done0 : done1;
      if (n == v.rdy + 2 && cmd_wr)
        smem[cmd_address] = merge(smem_rd(cmd_address), cmd_data_in, cmd_byte_enable);
      if (ackp) ack_cnt++;
      if (n == 1) begin
        chk("vec_ack", ackp, 1);
        set_port(v.port, 1'b0, v.wr, v.addr, v.wdata, v.be);
      end
      if (cmd_enable) begin
        en_cnt++;
        chk("vec_fields", {cmd_wr, cmd_address, cmd_data_in, cmd_byte_enable},
            {v.wr, v.addr, v.wdata, v.be});
      end
      if (donep) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        if (!v.wr) chk("vec_rdata", rdata, v.exp_rdata);
        chk("vec_busy_at_done", busy, 0);
      end
      chk("vec_other_port", {acko, doneo}, 2'b00);
      cmd_ready      = (v.rdy == 0) || (n + 1 >= v.rdy + 2);
      data_out_ready = !v.wr && (n + 1 == v.rdy + 2 + v.dly);
      data_out       = data_out_ready ? smem_rd(cmd_address) : $urandom();
    end
    chk("vec_done_latency", done_at, v.lat);
    chk("vec_done_count", done_cnt, 1);
    chk("vec_ack_count", ack_cnt, 1);
    chk("vec_enable_cycles", en_cnt, v.rdy + 1);
    data_out_ready = 0;
    cmd_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int ngr, done_at;
    logic [1:0] req_edge, exp_ack, exp_done;
    bit pre_busy, rdy_edge, dor_real, dor_edge, en_prev;
    bit m_busy, m_last, m_owner, w, rd_pend;
    int rd_wait;
    bit p_req[2], p_out[2], p_wr[2];
    logic [22:0] p_addr[2];
    logic [31:0] p_wdata[2], exp_data[2];
    logic [3:0]  p_be[2];

    vecs[0] = '{port:0, wr:1, addr:23'h000010, wdata:32'hA5A5_0001, be:4'hF, rdy:0,  dly:0, lat:2,  exp_rdata:32'h0};
    vecs[1] = '{port:1, wr:0, addr:23'h000010, wdata:32'h0,         be:4'hF, rdy:0,  dly:5, lat:7,  exp_rdata:32'hA5A5_0001};
    vecs[2] = '{port:1, wr:1, addr:23'h000020, wdata:32'h1234_5678, be:4'h3, rdy:2,  dly:0, lat:4,  exp_rdata:32'h0};
    vecs[3] = '{port:0, wr:0, addr:23'h000020, wdata:32'h0,         be:4'hF, rdy:1,  dly:1, lat:4,  exp_rdata:32'hDEAD_5678};
    vecs[4] = '{port:0, wr:0, addr:23'h7FFFFF, wdata:32'h0,         be:4'hF, rdy:0,  dly:1, lat:3,  exp_rdata:32'hDEAD_BEEF};
    vecs[5] = '{port:1, wr:1, addr:23'h7FFFFF, wdata:32'hFFFF_0000, be:4'hC, rdy:0,  dly:0, lat:2,  exp_rdata:32'h0};
    vecs[6] = '{port:1, wr:0, addr:23'h7FFFFF, wdata:32'h0,         be:4'hF, rdy:0,  dly:2, lat:4,  exp_rdata:32'hFFFF_BEEF};
    vecs[7] = '{port:0, wr:1, addr:23'h000033, wdata:32'hCAFE_F00D, be:4'hF, rdy:20, dly:0, lat:22, exp_rdata:32'h0};
    vecs[8] = '{port:0, wr:0, addr:23'h000033, wdata:32'h0,         be:4'hF, rdy:3,  dly:2, lat:7,  exp_rdata:32'hCAFE_F00D};

    // reset state
    tick();
    tick();
    chk("rst_ctl", {ack0, ack1, done0, done1, busy, timeout_err, cmd_enable, cmd_wr}, 0);
    chk("rst_addr", cmd_address, 0);
    chk("rst_data", {cmd_data_in, cmd_byte_enable}, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // both ports hold writes: strict alternation, one grant every 2 cycles
    pulse_reset();
    set_port(0, 1, 1, 23'h50, 32'h0000_0050, 4'hF);
    set_port(1, 1, 1, 23'h51, 32'h0000_0051, 4'hF);
    cmd_ready = 1;
    ngr = 0;
    for (int n = 1; n <= 20 && ngr < 6; n++) begin
      tick();
      chk("tie_both_ack", ack0 & ack1, 0);
      if (ack0 | ack1) begin
        chk("tie_order", ack1, ngr % 2);
        chk("tie_slot", n, 1 + 2 * ngr);
        chk("tie_addr", cmd_address, (ngr % 2) ? 23'h51 : 23'h50);
        ngr++;
      end
    end
    chk("tie_count", ngr, 6);
    req0 = 0; req1 = 0;
    tick();
    tick();
    chk("tie_idle", busy, 0);

    // randomized run against the reference model
    pulse_reset();
    m_busy = 0; m_last = 1; m_owner = 0; rd_pend = 0; rd_wait = 0;
    en_prev = 0; dor_real = 0; w = 0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_out[p] = 0; p_wr[p] = 0; p_addr[p] = 0;
      p_wdata[p] = 0; p_be[p] = 0; exp_data[p] = 0;
    end
    for (int cyc = 0; cyc < 900; cyc++) begin
      req_edge = {req1, req0};
      pre_busy = m_busy;
      rdy_edge = cmd_ready;
      dor_edge = dor_real;
      tick();
      exp_done = 2'b00;
      if (en_prev && rdy_edge) begin
        if (cmd_wr) begin
          smem[cmd_address] = merge(smem_rd(cmd_address), cmd_data_in, cmd_byte_enable);
          exp_done[m_owner] = 1'b1;
        end else begin
          rd_pend = 1;
          rd_wait = $urandom_range(0, 3);
        end
      end
      if (dor_edge) exp_done[m_owner] = 1'b1;
      exp_ack = 2'b00;
      if (!pre_busy && req_edge != 2'b00) begin
        w = (req_edge == 2'b11) ? ~m_last : req_edge[1];
        exp_ack[w] = 1'b1;
      end
      chk("rnd_ack", {ack1, ack0}, exp_ack);
      chk("rnd_done", {done1, done0}, exp_done);
      if (exp_done != 2'b00) begin
        if (!p_wr[m_owner]) chk("rnd_rdata", rdata, exp_data[m_owner]);
        m_busy = 0;
        p_out[m_owner] = 0;
      end
      if (exp_ack != 2'b00) begin
        chk("rnd_fields", {cmd_wr, cmd_address, cmd_data_in, cmd_byte_enable},
            {p_wr[w], p_addr[w], p_wdata[w], p_be[w]});
        if (p_wr[w]) gmem[p_addr[w]] = merge(gmem_rd(p_addr[w]), p_wdata[w], p_be[w]);
        else         exp_data[w] = gmem_rd(p_addr[w]);
        m_last = w; m_owner = w; m_busy = 1;
        p_req[w] = 0; p_out[w] = 1;
      end
      chk("rnd_busy", busy, m_busy);
      chk("rnd_terr", timeout_err, 0);
      en_prev = cmd_enable;
      cmd_ready = ($urandom_range(0, 2) != 0);
      dor_real = 0;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          data_out_ready = 1; data_out = smem_rd(cmd_address);
          rd_pend = 0; dor_real = 1;
        end else begin
          rd_wait--; data_out_ready = 0; data_out = $urandom();
        end
      end else begin
        data_out_ready = ($urandom_range(0, 7) == 0);
        data_out = $urandom();
      end
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && !p_out[p] && cyc < 800 && $urandom_range(0, 2) == 0) begin
          p_req[p]   = 1;
          p_wr[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = 23'h100 + 23'($urandom_range(0, 7));
          p_wdata[p] = $urandom();
          p_be[p]    = 4'($urandom_range(0, 15));
        end
      end
      req0 = p_req[0]; wr0 = p_wr[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0]; be0 = p_be[0];
      req1 = p_req[1]; wr1 = p_wr[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1]; be1 = p_be[1];
    end
    chk("rnd_drain", {p_req[0], p_req[1], p_out[0], p_out[1], m_busy}, 0);
    data_out_ready = 0;

    // timeout on the TIMEOUT=16 instance; rdata primed by a good read first
    pulse_reset();
    run_vec('{port:0, wr:0, addr:23'h000010, wdata:32'h0, be:4'hF, rdy:0, dly:1, lat:3,
              exp_rdata:32'hA5A5_0001});
    chk("to_prime", rdata_t, 32'hA5A5_0001);
    set_port(1, 1, 0, 23'h40, 32'h0, 4'hF);
    cmd_ready = 1;
    data_out_ready = 0;
    done_at = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      tick();
      if (n == 1) begin
        chk("to_ack", {ack1_t, ack0_t}, 2'b10);
        chk("to_fields", {en_t, cwr_t, caddr_t, cdata_t, cbe_t}, {1'b1, 1'b0, 23'h40, 32'h0, 4'hF});
        req1 = 0;
      end
      if (n == 16) chk("to_err_pre", terr_t, 0);
      if (done0_t | done1_t) begin
        done_at = n;
        chk("to_done_port", {done1_t, done0_t}, 2'b10);
        chk("to_err", terr_t, 1);
        chk("to_rdata_kept", rdata_t, 32'hA5A5_0001);
      end
    end
    chk("to_done_at", done_at, 17);
    data_out = 32'h1111_2222;
    data_out_ready = 1;
    tick();
    data_out_ready = 0;
    chk("to_late_ignored", {done1_t, done0_t, busy_t}, 0);
    chk("to_late_rdata", rdata_t, 32'hA5A5_0001);
    tick();
    tick();
    chk("to_sticky", terr_t, 1);
    chk("to_main_no_err", timeout_err, 0);

    // reset asserted while the main instance waits for read data
    set_port(0, 1, 0, 23'h60, 32'h0, 4'hF);
    cmd_ready = 1;
    tick();
    chk("mr_ack", ack0, 1);
    req0 = 0;
    tick();
    tick();
    chk("mr_busy_before", busy, 1);
    chk("mr_rdata_before", rdata, 32'h1111_2222);
    #2 rst = 1;
    #1;
    chk("mr_ctl", {ack0, ack1, done0, done1, busy, timeout_err, cmd_enable, cmd_wr}, 0);
    chk("mr_fields", {cmd_address, cmd_data_in, cmd_byte_enable}, 0);
    chk("mr_rdata", rdata, 0);
    chk("mr_terr_cleared", terr_t, 0);
    tick();
    chk("mr_no_done_rst", {done0, done1}, 0);
    rst = 0;
    tick();
    chk("mr_no_done_after", {done0, done1, busy}, 0);
    set_port(0, 1, 1, 23'h70, 32'h70, 4'hF);
    set_port(1, 1, 1, 23'h71, 32'h71, 4'hF);
    tick();
    chk("mr_tie_port0", {ack1, ack0}, 2'b01);
    req0 = 0; req1 = 0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
